op_issuer: RTL and testbench

OP_ISSUER -- requirements
Module: op_issuer

---
 rtl/op_issuer.sv | 157 +++++++++++++++
 tb/tb_op_issuer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/op_issuer.sv
// Command FIFO plus issue sequencer: replays queued operation words to the controller,
// holding multiplies for a fixed time and streaming data words under write commands.
module op_issuer #(
  parameter int MULT_CYCLES = 80,
  parameter int WRITE_LEN   = 64,
  parameter int FIFO_DEPTH  = 4   // power of two, at least 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] cmd_word,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [31:0] operation,
  output logic [31:0] in_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_MAX = (MULT_CYCLES > WRITE_LEN) ? MULT_CYCLES : WRITE_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, MULT, WRITE, GAP} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [31:0]        op_reg, op_next;
  logic [31:0]        in_data_reg, in_data_next;
  logic [31:0]        word_reg, word_next;
  logic               err_reg, err_next;
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [OCC_W-1:0]   occ_reg;
  logic [31:0]        fifo_mem [FIFO_DEPTH];

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic [31:0] head;

  assign full       = (occ_reg == OCC_W'(FIFO_DEPTH));
  assign empty      = (occ_reg == '0);
  assign cmd_ready  = enable && !full;
  assign push       = cmd_valid && cmd_ready;
  assign head       = fifo_mem[rd_ptr_reg];
  assign data_ready = enable && (state_reg == WRITE) && (cnt_reg < CNT_W'(WRITE_LEN));

  assign operation = op_reg;
  assign in_data   = in_data_reg;
  assign busy      = (state_reg != IDLE) || !empty;
  assign done      = (state_reg == GAP);
  assign err       = err_reg;

  // GAP dispatches the next queued command itself so back-to-back commands see a single zero cycle.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    op_next      = op_reg;
    in_data_next = in_data_reg;
    word_next    = word_reg;
    err_next     = err_reg;
    pop          = 1'b0;
    if (enable) begin
      case (state_reg)
        IDLE, GAP: begin
          state_next = IDLE;
          op_next    = '0;
          if (!empty) begin
            pop      = 1'b1;
            cnt_next = '0;
            case (head[3:0])
              4'd0: ;
              4'd1: begin
                state_next = MULT;
                op_next    = head;
                word_next  = head;
              end
              4'd2: begin
                state_next = WRITE;
                word_next  = head;
              end
              default: err_next = 1'b1;
            endcase
          end
        end
        MULT: begin
          if (cnt_reg == CNT_W'(MULT_CYCLES - 1)) begin
            state_next = GAP;
            op_next    = '0;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        WRITE: begin
          if (cnt_reg == CNT_W'(WRITE_LEN)) begin
            state_next = GAP;
            op_next    = '0;
            cnt_next   = '0;
          end else if (data_valid) begin
            in_data_next = data_in;
            op_next      = word_reg;
            cnt_next     = cnt_reg + 1'b1;
          end else begin
            op_next = '0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      op_reg      <= '0;
      in_data_reg <= '0;
      word_reg    <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      op_reg      <= op_next;
      in_data_reg <= in_data_next;
      word_reg    <= word_next;
      err_reg     <= err_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + 1'b1;
        2'b01:   occ_reg <= occ_reg - 1'b1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= cmd_word;
  end

endmodule

// File: tb/tb_op_issuer.sv
// Directed bench for op_issuer: multiply hold, streamed write with bubbles, FIFO back-pressure,
// bad opcode handling, enable freeze and mid-command reset.
module tb_op_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] cmd_word;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] operation;
  logic [31:0] in_data;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [31:0] run_val[$];
  int          run_len[$];

  op_issuer dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cmd_word(cmd_word), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .operation(operation), .in_data(in_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Run-length log of the operation output, one entry per distinct consecutive value.
  task automatic step_rec();
    step();
    if (run_val.size() == 0 || run_val[run_val.size()-1] !== operation) begin
      run_val.push_back(operation);
      run_len.push_back(1);
    end else begin
      run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
    end
  endtask

  initial begin
    int n, g, idx, opcnt, bad, sev, acc_cnt;
    logic acc;
    logic [31:0] words [5];
    words[0] = 32'h0000_0011; words[1] = 32'h0000_0021; words[2] = 32'h0000_0031;
    words[3] = 32'h0000_0041; words[4] = 32'h0000_0051;

    reset = 1'b1; enable = 1'b1; cmd_word = '0; cmd_valid = 1'b0;
    data_in = '0; data_valid = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_op", operation, 32'h0);
    chk("rst_in_data", in_data, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_data_ready", data_ready, 1'b0);

    // Single multiply: 80-cycle hold, one done cycle, then idle.
    cmd_word = 32'h0000_1891; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("mul_lat0_op", operation, 32'h0);
    chk("mul_lat0_busy", busy, 1'b1);
    step();
    chk("mul_first_op", operation, 32'h0000_1891);
    n = 0;
    while (operation === 32'h0000_1891 && n < 200) begin
      n++;
      step();
    end
    chk("mul_hold", n, 80);
    chk("mul_end_op", operation, 32'h0);
    chk("mul_done", done, 1'b1);
    step();
    chk("mul_done_pulse", done, 1'b0);
    chk("mul_idle_busy", busy, 1'b0);

    // Write: 64 words with data_valid low every 4th cycle.
    cmd_word = 32'h0000_0F82; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    idx = 0; opcnt = 0; bad = 0; g = 0;
    while (done !== 1'b1 && g < 400) begin
      data_valid = ((g % 4) != 3) && (idx < 64);
      data_in    = idx;
      acc        = data_valid && data_ready;
      step();
      if (acc) begin
        if (in_data !== 32'(idx) || operation !== 32'h0000_0F82) bad++;
        idx++;
      end else if (operation !== 32'h0) begin
        bad++;
      end
      if (operation === 32'h0000_0F82) opcnt++;
      g++;
    end
    data_valid = 1'b0;
    chk("wr_words", idx, 64);
    chk("wr_op_cycles", opcnt, 64);
    chk("wr_order_bubble", bad, 0);
    chk("wr_done", done, 1'b1);
    chk("wr_gap_op", operation, 32'h0);
    chk("wr_last_data", in_data, 32'd63);
    step();
    chk("wr_idle_busy", busy, 1'b0);

    // Five multiplies pushed back-to-back; FIFO fills at four.
    run_val.delete(); run_len.delete();
    for (int k = 0; k < 5; k++) begin
      cmd_word = words[k]; cmd_valid = 1'b1;
      g = 0;
      while (cmd_ready !== 1'b1 && g < 1000) begin
        step_rec();
        g++;
      end
      step_rec();
    end
    cmd_valid = 1'b0;
    chk("b2b_full_ready", cmd_ready, 1'b0);
    g = 0;
    while (busy === 1'b1 && g < 700) begin
      step_rec();
      g++;
    end
    chk("b2b_drain", busy, 1'b0);
    chk("b2b_runs", run_val.size(), 11);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("b2b_word%0d", k), run_val[2*k+1], words[k]);
      chk($sformatf("b2b_len%0d", k), run_len[2*k+1], 80);
      if (k < 4) chk($sformatf("b2b_gap%0d", k), run_len[2*k+2], 1);
    end

    // Unsupported opcode followed by a multiply.
    run_val.delete(); run_len.delete();
    cmd_word = 32'h0000_0007; cmd_valid = 1'b1;
    step_rec();
    cmd_word = 32'h0000_1891;
    step_rec();
    cmd_valid = 1'b0;
    g = 0;
    while (busy === 1'b1 && g < 300) begin
      step_rec();
      g++;
    end
    sev = 0;
    foreach (run_val[i]) if (run_val[i] === 32'h0000_0007) sev++;
    chk("bad_err", err, 1'b1);
    chk("bad_never_issued", sev, 0);
    chk("bad_mul_word", run_val[1], 32'h0000_1891);
    chk("bad_mul_len", run_len[1], 80);

    // Enable low for 10 cycles in the middle of a multiply.
    cmd_word = 32'h0000_1891; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    n = (operation === 32'h0000_1891) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (operation === 32'h0000_1891) n++;
    end
    enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (operation !== 32'h0000_1891 || done !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk("frz_outputs", bad, 0);
    chk("frz_cmd_ready", cmd_ready, 1'b0);
    enable = 1'b1;
    g = 0;
    while (operation === 32'h0000_1891 && g < 200) begin
      step();
      if (operation === 32'h0000_1891) n++;
      g++;
    end
    chk("frz_hold", n, 80);
    chk("frz_done", done, 1'b1);
    chk("frz_err_sticky", err, 1'b1);
    step();

    // Reset partway through a write with a second command queued.
    cmd_word = 32'h0000_0F82; cmd_valid = 1'b1;
    step();
    cmd_word = 32'h0000_1891;
    step();
    cmd_valid = 1'b0;
    data_valid = 1'b1;
    acc_cnt = 0; g = 0;
    while (acc_cnt < 30 && g < 100) begin
      data_in = 32'h100 + acc_cnt;
      acc = data_ready;
      step();
      if (acc) acc_cnt++;
      g++;
    end
    chk("rw_mid_op", operation, 32'h0000_0F82);
    reset = 1'b1;
    data_valid = 1'b0;
    step();
    reset = 1'b0;
    chk("rw_op", operation, 32'h0);
    chk("rw_busy", busy, 1'b0);
    chk("rw_err", err, 1'b0);
    chk("rw_in_data", in_data, 32'h0);
    chk("rw_cmd_ready", cmd_ready, 1'b1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done !== 1'b0 || operation !== 32'h0 || busy !== 1'b0) bad++;
    end
    chk("rw_quiet", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
